sram_line_ctrl: RTL and testbench
=================================

# sram_line_ctrl

Initiator side of the cache data-array SRAM port: it accepts whole-line read or write requests from the cache pipeline and sequences them into per-word SRAM accesses. It drives the shared `ce`/`we`/`addr`/`w_data` bus and the per-way enables of the `WAY_NUM` data-array macros, and collects the registered read data. It returns each completed line through a valid/ready response channel. It sits between the cache controller FSM and the data-array macros.

## Interface
- `DATA_W`, 32, SRAM word width
- `ADDR_W`, 8, SRAM word-address width
- `BEATS`, 4, words per cache line; power of two, ≥2, ≤ 2^ADDR_W
- `WAY_NUM`, 4, number of data-array ways (one macro each)
- `WAY_W`, $clog2(WAY_NUM) (min 1), way index width (derived)
- `LINE_W`, ADDR_W-$clog2(BEATS), line index width (derived)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  line request valid
- `req_ready`  out  1  controller can accept a request
- `req_we`  in  1  0 = read line, 1 = write line
- `req_way`  in  WAY_W  target way index
- `req_line`  in  LINE_W  line index
- `req_wdata`  in  DATA_W*BEATS  write line; beat k = `[k*DATA_W +: DATA_W]`
- `rsp_valid`  out  1  request complete
- `rsp_ready`  in  1  consumer accepts response
- `rsp_rdata`  out  DATA_W*BEATS  read line, same beat packing
- `rsp_err`  out  1  `req_way` ≥ WAY_NUM; no macro was enabled
- `sram_ce`  out  1  chip enable to all macros
- `sram_way_en`  out  WAY_NUM  one-hot way enable
- `sram_we`  out  1  0 = read, 1 = write
- `sram_addr`  out  ADDR_W  word address
- `sram_wdata`  out  DATA_W  write word
- `sram_rdata`  in  DATA_W  OR of macro read data; valid the cycle after a read access

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `we`, `way`, `line` and `wdata`.
  - Clear the beat counter and `rsp_rdata`.
  - Go to WRITE if `we` = 1, else READ.
- WRITE, one beat per cycle, k = 0..BEATS-1:
  - `sram_ce` = 1, `sram_we` = 1.
  - `sram_addr` = {line, k[$clog2(BEATS)-1:0]}, `sram_wdata` = beat k.
  - After beat BEATS-1, go to RESP.
- READ:
  - Same address sequence with `sram_we` = 0.
  - Read data for beat k is captured into `rsp_rdata` beat k on the edge ending the cycle after beat k was issued.
  - After issuing beat BEATS-1, go to DRAIN.
- DRAIN:
  - `sram_ce` = 0.
  - Capture the last beat, then go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
- Way enable:
  - `sram_way_en` = one-hot of the latched way while `sram_ce` = 1, else 0.
  - If way ≥ WAY_NUM, `sram_way_en` = 0 for the whole operation and the beat sequence still runs.
  - In that case `rsp_err` = 1 and read data = 0, because the macros output 0 when disabled and the OR-bus captures 0.
- For write requests, `rsp_rdata` = 0.
- `sram_wdata` = 0 whenever not in WRITE.
- No request queuing: exactly one request is in flight at a time.

## Timing
- Reset (async assert, any state): go to IDLE immediately.
  - Outputs during reset: `req_ready` = 0 while `rst_n` = 0, then 1 in IDLE.
  - All other outputs are 0: `rsp_valid`, `rsp_err`, `rsp_rdata`, `sram_ce`, `sram_we`, `sram_way_en`, `sram_addr`, `sram_wdata`.
  - A write interrupted by reset leaves beats 0..k-1 written and the rest untouched; there is no rollback.
- Acceptance at edge E0:
  - Beat 0 is driven in the cycle after E0.
  - Write: `rsp_valid` rises BEATS+1 cycles after E0.
  - Read: `rsp_valid` rises BEATS+2 cycles after E0.
- `req_ready` depends only on state (IDLE), with no combinational path from `rsp_ready`.
  - Minimum spacing from one acceptance to the next: BEATS+3 cycles for a read, BEATS+2 for a write.
- `rsp_valid` is held with stable data until `rsp_ready`.
  - `rsp_ready` asserted before `rsp_valid` has no effect.
- `req_*` inputs are ignored outside IDLE; they are latched only at the acceptance edge.

## Structure
- `cache_pkg`: state enum `line_st_e` {IDLE, WRITE, READ, DRAIN, RESP}.
- `cache_pkg`: function `way_onehot(idx, n)` producing the way-enable vector.
- Single module; no sub-module is required.
- Bench instantiates WAY_NUM data-array SRAM macros with OR-combined read data, so the bench must gate each macro's read data with its way enable.

## Test plan
- Write then read:
  - Write way 2, line 5, beats {0x11,0x22,0x33,0x44}.
  - Then read way 2, line 5.
  - Required: `sram_addr` 0x14..0x17 on both passes; `rsp_rdata` = {0x44,0x33,0x22,0x11} (beat3..0); `rsp_valid` at E0+5 for the write and E0+6 for the read.
- Way isolation:
  - Write line 0 in way 0, then read line 0 from way 1.
  - Required: all-zero data; `sram_way_en` = 4'b0010 during the read.
- Bad way (WAY_NUM = 3, `req_way` = 3):
  - Required: `sram_way_en` = 0 throughout, `rsp_err` = 1, `rsp_rdata` = 0, full beat sequence timing preserved.
- Backpressure:
  - Hold `rsp_ready` = 0 for 10 cycles with `req_valid` = 1 continuously.
  - Required: `rsp_rdata` stable, `req_ready` = 0, no SRAM access (`sram_ce` = 0) until the response handshake.
- Reset mid-write:
  - Deassert `rst_n` during beat 2.
  - Required: outputs 0 asynchronously; a subsequent read returns new beats 0–1 and old beats 2–3.
- Wrap/boundary:
  - Read the last line (`req_line` = all ones).
  - Required: addresses run 0xFC..0xFF with no wrap to 0x00.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache data-array line controller.
package cache_pkg;

  // Widest way-enable vector the helper can build; callers truncate to WAY_NUM.
  localparam int MAX_WAYS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } line_st_e;

  // One-hot enable for way idx among n ways; an out-of-range idx yields all zeros,
  // so a bad way simply enables no macro.
  function automatic logic [MAX_WAYS-1:0] way_onehot(input logic [31:0] idx,
                                                     input logic [31:0] n);
    logic [MAX_WAYS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if ((32'(i) < n) && (idx == 32'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sram_line_ctrl.sv
// Sequences whole-line read/write requests into per-word accesses on the shared
// data-array SRAM bus and returns each completed line on a valid/ready channel.
module sram_line_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int BEATS   = 4,
  parameter int WAY_NUM = 4,
  parameter int WAY_W   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  parameter int LINE_W  = ADDR_W - $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [WAY_W-1:0]        req_way,
  input  logic [LINE_W-1:0]       req_line,
  input  logic [DATA_W*BEATS-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W*BEATS-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    sram_ce,
  output logic [WAY_NUM-1:0]      sram_way_en,
  output logic                    sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_wdata,
  input  logic [DATA_W-1:0]       sram_rdata
);

  localparam int BW = $clog2(BEATS);
  localparam int LW = DATA_W * BEATS;

  line_st_e            state_q, state_d;
  logic [BW-1:0]       cnt_q, cnt_d;         // beat currently on the bus
  logic                we_q, we_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LW-1:0]       wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [LW-1:0]       rdata_q, rdata_d;
  logic                cap_vld_q, cap_vld_d; // read data for cap_idx_q is on sram_rdata
  logic [BW-1:0]       cap_idx_q, cap_idx_d;
  logic                ce_q, ce_d;
  logic                swe_q, swe_d;
  logic [WAY_NUM-1:0]  way_en_q, way_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   swdata_q, swdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [BW-1:0]       cnt_nxt;

  // ready is a pure function of state; forced low while reset is held
  assign req_ready   = rst_n && (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q && rsp_valid_q;
  assign sram_ce     = ce_q;
  assign sram_way_en = way_en_q;
  assign sram_we     = swe_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = swdata_q;

  // Next-state, next-beat bus values and read-data capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    way_d       = way_q;
    line_d      = line_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    cap_vld_d   = 1'b0;
    cap_idx_d   = cap_idx_q;
    ce_d        = ce_q;
    swe_d       = swe_q;
    way_en_d    = way_en_q;
    addr_d      = addr_q;
    swdata_d    = swdata_q;
    rsp_valid_d = rsp_valid_q;
    cnt_nxt     = cnt_q + BW'(1);

    // Macro output is registered: data for a read issued this cycle lands next cycle.
    if (cap_vld_q) rdata_d[cap_idx_q*DATA_W +: DATA_W] = sram_rdata;
    if (ce_q && !swe_q) begin
      cap_vld_d = 1'b1;
      cap_idx_d = addr_q[BW-1:0];
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          way_d    = req_way;
          line_d   = req_line;
          wdata_d  = req_wdata;
          err_d    = (32'(req_way) >= 32'(WAY_NUM));
          rdata_d  = '0;
          cnt_d    = '0;
          state_d  = req_we ? WRITE : READ;
          // beat 0 goes out in the cycle right after acceptance
          ce_d     = 1'b1;
          swe_d    = req_we;
          way_en_d = WAY_NUM'(way_onehot(32'(req_way), 32'(WAY_NUM)));
          addr_d   = {req_line, BW'(0)};
          swdata_d = req_we ? req_wdata[DATA_W-1:0] : '0;
        end
      end
      WRITE, READ: begin
        if (cnt_q == BW'(BEATS - 1)) begin
          ce_d     = 1'b0;
          swe_d    = 1'b0;
          way_en_d = '0;
          addr_d   = '0;
          swdata_d = '0;
          if (state_q == WRITE) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d    = cnt_nxt;
          way_en_d = WAY_NUM'(way_onehot(32'(way_q), 32'(WAY_NUM)));
          addr_d   = {line_q, cnt_nxt};
          swdata_d = we_q ? wdata_q[cnt_nxt*DATA_W +: DATA_W] : '0;
        end
      end
      DRAIN: begin
        // last beat is captured on this edge by the cap_vld path above
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        ce_d        = 1'b0;
        swe_d       = 1'b0;
        way_en_d    = '0;
        addr_d      = '0;
        swdata_d    = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus immediately, no rollback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      way_q       <= '0;
      line_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      ce_q        <= 1'b0;
      swe_q       <= 1'b0;
      way_en_q    <= '0;
      addr_q      <= '0;
      swdata_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      way_q       <= way_d;
      line_q      <= line_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
      ce_q        <= ce_d;
      swe_q       <= swe_d;
      way_en_q    <= way_en_d;
      addr_q      <= addr_d;
      swdata_q    <= swdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Bench for sram_line_ctrl with three data-array macro models (so way 3 is out of range).
module tb_sram_line_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BT = 4;
  localparam int WN = 3;
  localparam int WW = 2;
  localparam int LNW = 6;
  localparam int LW = DW * BT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [WW-1:0] req_way;
  logic [LNW-1:0] req_line;
  logic [LW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [LW-1:0] rsp_rdata;
  logic          sram_ce, sram_we;
  logic [WN-1:0] sram_way_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  sram_line_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BEATS(BT), .WAY_NUM(WN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_way(req_way), .req_line(req_line), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_ce(sram_ce), .sram_way_en(sram_way_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro models: registered read data, zero when the macro is not enabled
  logic [DW-1:0] mem [WN][256];
  logic [DW-1:0] rd_q [WN];
  initial begin
    for (int w = 0; w < WN; w++) begin
      rd_q[w] = '0;
      for (int a = 0; a < 256; a++) mem[w][a] = '0;
    end
  end
  always @(posedge clk) begin
    for (int w = 0; w < WN; w++) begin
      if (sram_ce && sram_way_en[w] && sram_we) mem[w][sram_addr] <= sram_wdata;
      rd_q[w] <= (sram_ce && sram_way_en[w] && !sram_we) ? mem[w][sram_addr] : '0;
    end
  end
  always_comb begin
    sram_rdata = '0;
    for (int w = 0; w < WN; w++) sram_rdata = sram_rdata | rd_q[w];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bus access log
  typedef struct {
    logic [WN-1:0] wen;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } acc_t;
  acc_t acc_log[$];
  always @(negedge clk) if (sram_ce) acc_log.push_back('{sram_way_en, sram_we, sram_addr, sram_wdata});

  // Scoreboard
  typedef struct {
    logic [LW-1:0] rd;
    logic          err;
    int            c0;
    int            lat;   // cycle (1 = cycle right after acceptance) in which rsp_valid is first seen
  } exp_t;
  exp_t sb[$];

  logic prev_vld = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prev_vld) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_latency", LW'(cyc - sb[0].c0 + 1), LW'(sb[0].lat));
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", LW'(rsp_err), LW'(e.err));
      end
      prev_vld = rsp_valid;
    end
  end

  task automatic do_req(input logic we, input logic [WW-1:0] way, input logic [LNW-1:0] line,
                        input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd,
                        input logic exp_err, input logic keep);
    logic ok;
    acc_log.delete();
    req_we = we; req_way = way; req_line = line; req_wdata = wd; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("accept", LW'(ok), 1);
    @(posedge clk); #1;
    sb.push_back('{exp_rd, exp_err, cyc, we ? BT + 1 : BT + 2});
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin ok = 1'b1; break; end
    end
    chk("done", LW'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input int n, input logic [AW-1:0] base, input logic we,
                           input logic [WN-1:0] wen, input logic [LW-1:0] wd);
    chk("log_len", LW'(acc_log.size()), LW'(n));
    for (int i = 0; i < acc_log.size() && i < n; i++) begin
      chk("addr", LW'(acc_log[i].addr), LW'(32'(base) + i));
      chk("we", LW'(acc_log[i].we), LW'(we));
      chk("way_en", LW'(acc_log[i].wen), LW'(wen));
      chk("wdata", LW'(acc_log[i].wd), we ? LW'(wd[i*DW +: DW]) : '0);
    end
  endtask

  localparam logic [LW-1:0] L1  = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [LW-1:0] L2  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [LW-1:0] L3  = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
  localparam logic [LW-1:0] OLD = {32'h0D0D0003, 32'h0D0D0002, 32'h0D0D0001, 32'h0D0D0000};
  localparam logic [LW-1:0] NEW = {32'hBEEF0003, 32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000};
  localparam logic [LW-1:0] MIX = {32'h0D0D0003, 32'h0D0D0002, 32'hBEEF0001, 32'hBEEF0000};

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_way = '0; req_line = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", LW'(req_ready), 0);
    chk("rst_rsp_valid", LW'(rsp_valid), 0);
    chk("rst_sram_ce", LW'(sram_ce), 0);
    chk("rst_way_en", LW'(sram_way_en), 0);
    chk("rst_addr", LW'(sram_addr), 0);
    chk("rst_rdata", rsp_rdata, '0);
    rst_n = 1'b1; #1;
    chk("idle_req_ready", LW'(req_ready), 1);
    @(posedge clk); #1;

    // write then read back way 2 line 5
    do_req(1'b1, 2'd2, 6'd5, L1, '0, 1'b0, 1'b0); wait_done();
    check_log(4, 8'h14, 1'b1, 3'b100, L1);
    do_req(1'b0, 2'd2, 6'd5, '0, L1, 1'b0, 1'b0); wait_done();
    check_log(4, 8'h14, 1'b0, 3'b100, '0);

    // way isolation
    do_req(1'b1, 2'd0, 6'd0, L2, '0, 1'b0, 1'b0); wait_done();
    do_req(1'b0, 2'd1, 6'd0, '0, '0, 1'b0, 1'b0); wait_done();
    check_log(4, 8'h00, 1'b0, 3'b010, '0);

    // out-of-range way: beats still run, nothing enabled, error flagged
    do_req(1'b1, 2'd3, 6'd1, L3, '0, 1'b1, 1'b0); wait_done();
    check_log(4, 8'h04, 1'b1, 3'b000, L3);
    do_req(1'b0, 2'd3, 6'd5, '0, '0, 1'b1, 1'b0); wait_done();
    check_log(4, 8'h14, 1'b0, 3'b000, '0);

    // backpressure with req_valid held high throughout
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 6'd5, '0, L1, 1'b0, 1'b1);
    req_we = 1'b0; req_way = 2'd1; req_line = 6'd9;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("bp_rsp_seen", LW'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rdata", rsp_rdata, L1);
      chk("bp_req_ready", LW'(req_ready), 0);
      chk("bp_sram_ce", LW'(sram_ce), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_req(1'b0, 2'd1, 6'd9, '0, '0, 1'b0, 1'b0); wait_done();

    // reset in the middle of a write
    do_req(1'b1, 2'd1, 6'd3, OLD, '0, 1'b0, 1'b0); wait_done();
    do_req(1'b1, 2'd1, 6'd3, NEW, '0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sram_ce && sram_addr[1:0] == 2'd2) begin ok = 1'b1; break; end
    end
    chk("mid_beat2_seen", LW'(ok), 1);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_ce", LW'(sram_ce), 0);
    chk("mid_rst_we", LW'(sram_we), 0);
    chk("mid_rst_way_en", LW'(sram_way_en), 0);
    chk("mid_rst_addr", LW'(sram_addr), 0);
    chk("mid_rst_wdata", LW'(sram_wdata), 0);
    chk("mid_rst_req_ready", LW'(req_ready), 0);
    chk("mid_rst_rsp_valid", LW'(rsp_valid), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'd1, 6'd3, '0, MIX, 1'b0, 1'b0); wait_done();

    // last line: addresses must stop at 0xFF
    do_req(1'b1, 2'd0, 6'h3F, L3, '0, 1'b0, 1'b0); wait_done();
    check_log(4, 8'hFC, 1'b1, 3'b001, L3);
    do_req(1'b0, 2'd0, 6'h3F, '0, L3, 1'b0, 1'b0); wait_done();
    check_log(4, 8'hFC, 1'b0, 3'b001, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
